// File: rtl/spi_regs_mc_pkg.sv
// Shared constants for the SPI master PicoBlaze register bank:
// register offsets within the bank and bit positions in SPSR and XSR.
package spi_pkg;

    localparam logic [2:0] SPCR_OFS = 3'd0;
    localparam logic [2:0] SPER_OFS = 3'd1;
    localparam logic [2:0] SPSR_OFS = 3'd2;
    localparam logic [2:0] SPDR_OFS = 3'd3;
    localparam logic [2:0] SSR_OFS  = 3'd4;
    localparam logic [2:0] XSR_OFS  = 3'd5;
    localparam logic [2:0] XCNT_OFS = 3'd6;
    localparam logic [2:0] IER_OFS  = 3'd7;

    localparam int unsigned SPIF_BIT = 7;
    localparam int unsigned WCOL_BIT = 6;

    localparam int unsigned XSR_OVF_BIT     = 0;
    localparam int unsigned XSR_RFEMPTY_BIT = 1;
    localparam int unsigned XSR_WFFULL_BIT  = 2;

endpackage

// File: rtl/spi_regs_mc_strobe_pulse.sv
// Rising-edge detector on a strobe-and-hit condition, producing a
// registered single-cycle pulse the cycle after the condition rises.
module spi_strobe_pulse (
    input  logic clk,
    input  logic reset,
    input  logic cond,
    output logic pulse
);

    logic cond_q;

    // Remember the previous condition and fire only on its rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            cond_q <= cond;
            pulse  <= cond && !cond_q;
        end
    end

endmodule

// File: rtl/spi_regs_mc.sv
// PicoBlaze port-mapped register bank for one SPI master channel.
// Optional interrupt enable register and irq output: define SPI_REGS_MC_IRQ_EN.
module spi_regs_mc
    import spi_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter int unsigned NUM_SS       = 4,
    parameter logic [NUM_SS-1:0] SS_RESET = {NUM_SS{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    input  logic              read_strobe,
    input  logic              write_strobe,
    input  logic [7:0]        rfdout,
    input  logic              rfempty,
    input  logic              wffull,
    input  logic [7:0]        spsr,
    output logic              wfwe,
    output logic [7:0]        wfdin,
    output logic              rfre,
    output logic              clear_spif,
    output logic              clear_wcol,
    output logic [7:0]        spcr,
    output logic [7:0]        sper,
    output logic [NUM_SS-1:0] ss_n,
    output logic              irq
);

    logic [7:0] offset;
    logic       in_bank;
    logic [2:0] ofs;
    logic       wr_en;
    logic       rd_en;
    logic       push_cond;
    logic       pop_cond;
    logic       spif_cond;
    logic       wcol_cond;
    logic       ovf;
    logic [7:0] xcnt;
    logic [7:0] ssr_rd;
    logic [7:0] xsr_rd;
    logic [7:0] ier_rd;
    logic [7:0] rd_mux;

    // Bank decode: offset relative to the base, valid when below 8.
    always_comb begin
        offset    = port_id - BASE_ADDRESS;
        in_bank   = (offset[7:3] == 5'd0);
        ofs       = offset[2:0];
        wr_en     = write_strobe && in_bank;
        rd_en     = read_strobe && in_bank;
        push_cond = wr_en && (ofs == SPDR_OFS) && !wffull;
        pop_cond  = rd_en && (ofs == SPDR_OFS) && !rfempty;
        spif_cond = wr_en && (ofs == SPSR_OFS) && data_in[SPIF_BIT];
        wcol_cond = wr_en && (ofs == SPSR_OFS) && data_in[WCOL_BIT];
    end

    spi_strobe_pulse u_wfwe (.clk(clk), .reset(reset), .cond(push_cond), .pulse(wfwe));
    spi_strobe_pulse u_rfre (.clk(clk), .reset(reset), .cond(pop_cond),  .pulse(rfre));
    spi_strobe_pulse u_spif (.clk(clk), .reset(reset), .cond(spif_cond), .pulse(clear_spif));
    spi_strobe_pulse u_wcol (.clk(clk), .reset(reset), .cond(wcol_cond), .pulse(clear_wcol));

    // Writable registers, sticky overflow flag, push data latch and push counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            spcr  <= '0;
            sper  <= '0;
            ss_n  <= SS_RESET;
            ovf   <= 1'b0;
            xcnt  <= '0;
            wfdin <= '0;
        end else begin
            if (wr_en) begin
                case (ofs)
                    SPCR_OFS: spcr <= data_in;
                    SPER_OFS: sper <= data_in;
                    SSR_OFS:  ss_n <= data_in[NUM_SS-1:0];
                    XSR_OFS:  if (data_in[XSR_OVF_BIT]) ovf <= 1'b0;
                    default:  ;
                endcase
            end
            // A push refused by a full FIFO only raises OVF; wfdin is
            // frozen while wfwe is high so the FIFO sees stable data.
            if (wr_en && (ofs == SPDR_OFS)) begin
                if (wffull) begin
                    ovf <= 1'b1;
                end else if (!wfwe) begin
                    wfdin <= data_in;
                end
            end
            // Counter advances on the actual push pulse; a clear write wins.
            if (wr_en && (ofs == XCNT_OFS)) begin
                xcnt <= '0;
            end else if (wfwe) begin
                xcnt <= xcnt + 8'd1;
            end
        end
    end

`ifdef SPI_REGS_MC_IRQ_EN
    logic [2:0] ier;

    // Interrupt enables and registered interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            ier <= '0;
            irq <= 1'b0;
        end else begin
            if (wr_en && (ofs == IER_OFS)) begin
                ier <= data_in[2:0];
            end
            irq <= |(ier & {!rfempty, ovf, spsr[SPIF_BIT]});
        end
    end

    assign ier_rd = {5'd0, ier};
`else
    assign ier_rd = '0;
    assign irq    = 1'b0;
`endif

    // Read views of SSR and XSR, zero-filled above their defined bits.
    always_comb begin
        ssr_rd                  = '0;
        ssr_rd[NUM_SS-1:0]      = ss_n;
        xsr_rd                  = '0;
        xsr_rd[XSR_OVF_BIT]     = ovf;
        xsr_rd[XSR_RFEMPTY_BIT] = rfempty;
        xsr_rd[XSR_WFFULL_BIT]  = wffull;
    end

    // Read data selection by bank offset.
    always_comb begin
        rd_mux = '0;
        case (ofs)
            SPCR_OFS: rd_mux = spcr;
            SPER_OFS: rd_mux = sper;
            SPSR_OFS: rd_mux = spsr;
            SPDR_OFS: rd_mux = rfdout;
            SSR_OFS:  rd_mux = ssr_rd;
            XSR_OFS:  rd_mux = xsr_rd;
            XCNT_OFS: rd_mux = xcnt;
            IER_OFS:  rd_mux = ier_rd;
            default:  rd_mux = '0;
        endcase
    end

    // Read data is captured every cycle; unmapped addresses read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= in_bank ? rd_mux : 8'd0;
        end
    end

endmodule

// File: tb/tb_spi_regs_mc.sv
// Directed self-checking bench for spi_regs_mc at BASE_ADDRESS=8'h40, NUM_SS=4.
module tb_spi_regs_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] rfdout;
    logic       rfempty;
    logic       wffull;
    logic [7:0] spsr;
    logic       wfwe;
    logic [7:0] wfdin;
    logic       rfre;
    logic       clear_spif;
    logic       clear_wcol;
    logic [7:0] spcr;
    logic [7:0] sper;
    logic [3:0] ss_n;
    logic       irq;

    int total = 0;
    int bad   = 0;
    int nrfre;

    spi_regs_mc #(
        .BASE_ADDRESS(8'h40),
        .NUM_SS(4),
        .SS_RESET(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .data_out(data_out), .read_strobe(read_strobe), .write_strobe(write_strobe),
        .rfdout(rfdout), .rfempty(rfempty), .wffull(wffull), .spsr(spsr),
        .wfwe(wfwe), .wfdin(wfdin), .rfre(rfre), .clear_spif(clear_spif),
        .clear_wcol(clear_wcol), .spcr(spcr), .sper(sper), .ss_n(ss_n), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d);
        port_id      = addr;
        data_in      = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        port_id = addr;
        step();
        check(tag, data_out, exp);
    endtask

    initial begin
        reset = 1'b1; port_id = 8'h00; data_in = 8'h00;
        read_strobe = 1'b0; write_strobe = 1'b0;
        rfdout = 8'h00; rfempty = 1'b1; wffull = 1'b0; spsr = 8'h00;
        step(); step();
        reset = 1'b0;

        // Reset state
        check("rst_data_out", data_out, 8'h00);
        check("rst_spcr", spcr, 8'h00);
        check("rst_sper", sper, 8'h00);
        check("rst_ss_n", 8'(ss_n), 8'h0F);
        check("rst_pulses", {4'h0, wfwe, rfre, clear_spif, clear_wcol}, 8'h00);
        check("rst_irq", 8'(irq), 8'h00);
        rd(8'h40, 8'h00, "rd_spcr");
        rd(8'h41, 8'h00, "rd_sper");
        rd(8'h42, 8'h00, "rd_spsr");
        rd(8'h43, 8'h00, "rd_spdr");
        rd(8'h44, 8'h0F, "rd_ssr");
        rd(8'h45, 8'h02, "rd_xsr");
        rd(8'h46, 8'h00, "rd_xcnt");
        rd(8'h47, 8'h00, "rd_ier");
        check("idle_pulses", {4'h0, wfwe, rfre, clear_spif, clear_wcol}, 8'h00);

        // Plain register writes
        wr(8'h40, 8'h5A);
        check("spcr_wr", spcr, 8'h5A);
        wr(8'h41, 8'h3C);
        check("sper_wr", sper, 8'h3C);
        wr(8'h44, 8'hF2);
        check("ss_n_wr", 8'(ss_n), 8'h02);
        rd(8'h44, 8'h02, "rd_ssr_upper0");
        rd(8'h40, 8'h5A, "rd_spcr2");

        // Three accepted pushes
        for (int i = 0; i < 3; i++) begin
            wr(8'h43, 8'hA5);
            check("wfwe_hi", 8'(wfwe), 8'h01);
            check("wfdin", wfdin, 8'hA5);
            step();
            check("wfwe_lo", 8'(wfwe), 8'h00);
        end
        rd(8'h46, 8'h03, "xcnt_3");

        // Refused push sets OVF; write-1 clears it
        rfempty = 1'b0;
        wffull  = 1'b1;
        wr(8'h43, 8'h77);
        check("full_no_wfwe", 8'(wfwe), 8'h00);
        check("full_wfdin", wfdin, 8'hA5);
        step();
        check("full_no_wfwe2", 8'(wfwe), 8'h00);
        rd(8'h45, 8'h05, "xsr_ovf");
        wr(8'h45, 8'h01);
        rd(8'h45, 8'h04, "xsr_ovf_clr");
        rd(8'h46, 8'h03, "xcnt_held");
        wffull = 1'b0;

        // Held read strobe on SPDR gives one pop
        rfdout      = 8'h3C;
        port_id     = 8'h43;
        read_strobe = 1'b1;
        nrfre       = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) begin
                check("pop_rfre_first", 8'(rfre), 8'h01);
                check("pop_data", data_out, 8'h3C);
            end
            nrfre += int'(rfre);
        end
        read_strobe = 1'b0;
        step();
        nrfre += int'(rfre);
        check("pop_count", 8'(nrfre), 8'h01);

        // Empty read FIFO: no pop
        rfempty     = 1'b1;
        read_strobe = 1'b1;
        step();
        check("empty_no_rfre", 8'(rfre), 8'h00);
        read_strobe = 1'b0;
        step();
        check("empty_no_rfre2", 8'(rfre), 8'h00);

        // Status clear pulses
        wr(8'h42, 8'hC0);
        check("clr_both", {6'h0, clear_spif, clear_wcol}, 8'h03);
        step();
        check("clr_both_end", {6'h0, clear_spif, clear_wcol}, 8'h00);
        wr(8'h42, 8'h80);
        check("clr_spif_only", {6'h0, clear_spif, clear_wcol}, 8'h02);
        step();
        check("clr_spif_end", {6'h0, clear_spif, clear_wcol}, 8'h00);
        spsr = 8'h81;
        rd(8'h42, 8'h81, "rd_spsr_live");

        // Interrupts
`ifdef SPI_REGS_MC_IRQ_EN
        wr(8'h47, 8'h01);
        step();
        check("irq_on", 8'(irq), 8'h01);
        rd(8'h47, 8'h01, "rd_ier");
        wr(8'h47, 8'h00);
        step();
        check("irq_off", 8'(irq), 8'h00);
`else
        rfempty = 1'b0;
        wr(8'h47, 8'h07);
        step();
        check("irq_tied0", 8'(irq), 8'h00);
        rd(8'h47, 8'h00, "rd_ier_absent");
        rfempty = 1'b1;
`endif

        // Unmapped addresses and XCNT clear
        rd(8'h48, 8'h00, "unmapped_hi");
        rd(8'h3F, 8'h00, "unmapped_lo");
        wr(8'h46, 8'hFF);
        rd(8'h46, 8'h00, "xcnt_clr");

        // Reset sampled together with a push strobe
        port_id      = 8'h43;
        data_in      = 8'h11;
        write_strobe = 1'b1;
        reset        = 1'b1;
        step();
        write_strobe = 1'b0;
        reset        = 1'b0;
        check("rst_mid_wfwe", 8'(wfwe), 8'h00);
        check("rst_mid_ss_n", 8'(ss_n), 8'h0F);
        check("rst_mid_spcr", spcr, 8'h00);
        check("rst_mid_data", data_out, 8'h00);
        step();
        check("rst_mid_wfwe2", 8'(wfwe), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_regs_mc.md
Name: spi_regs_mc

Overview:
- Parametrised next-generation PicoBlaze port-mapped register bank for the SPI master core.
- Adds over the first-generation bank:
  - a data register (SPDR) with FIFO push/pop handshakes;
  - write-1-to-clear status flags;
  - an NUM_SS-bit slave-select register;
  - a FIFO-overflow sticky flag;
  - a transfer byte counter.
- Sits between the PicoBlaze I/O bus and the SPI core and FIFOs, one instance per SPI channel.

Parameters:
- BASE_ADDRESS, 8'h00, first port_id of the bank. Bank occupies BASE_ADDRESS..BASE_ADDRESS+7.
- NUM_SS, 4, number of active-low slave selects (1..8).
- SS_RESET, {NUM_SS{1'b1}}, reset value of ss_n (all deselected).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- port_id  input  8  PicoBlaze port address
- data_in  input  8  PicoBlaze write data
- data_out  output  8  registered read data
- read_strobe  input  1  PicoBlaze read strobe
- write_strobe  input  1  PicoBlaze write strobe
- rfdout  input  8  read FIFO head data
- rfempty  input  1  read FIFO empty
- wffull  input  1  write FIFO full
- spsr  input  8  core status (bit7 SPIF, bit6 WCOL)
- wfwe  output  1  write FIFO push pulse
- wfdin  output  8  write FIFO data
- rfre  output  1  read FIFO pop pulse
- clear_spif  output  1  one-cycle SPIF clear
- clear_wcol  output  1  one-cycle WCOL clear
- spcr  output  8  control register
- sper  output  8  extension register
- ss_n  output  NUM_SS  slave selects
- irq  output  1  interrupt request

Behaviour:

Address map (offset from BASE_ADDRESS):
- 0 SPCR, RW.
- 1 SPER, RW.
- 2 SPSR:
  - read returns spsr;
  - write bit7=1 pulses clear_spif, bit6=1 pulses clear_wcol.
- 3 SPDR:
  - write pushes to the write FIFO;
  - read returns rfdout and pops the read FIFO.
- 4 SSR, RW, low NUM_SS bits. Upper bits read 0 and are ignored on write.
- 5 XSR: bit0 OVF sticky, bit1 rfempty, bit2 wffull, others 0. Writing bit0=1 clears OVF.
- 6 XCNT, 8-bit count of accepted SPDR pushes. Any write clears it to 0.
- 7 IER (feature only), else reads 0.

Reset values:
- spcr=0, sper=0, ss_n=SS_RESET, data_out=0, OVF=0, XCNT=0.
- wfwe, rfre, clear_spif, clear_wcol all 0.
- irq=0.

Write path:
- A register write takes effect on the clk edge where write_strobe=1 and the address decode hits. The new value is visible on outputs the next cycle.
- wfwe, clear_spif and clear_wcol are registered one-cycle pulses, asserted the cycle after the strobe.
- wfdin holds data_in latched on the SPDR write and stays stable while wfwe is high.
- SPDR write with wffull=1:
  - no wfwe;
  - OVF set;
  - XCNT unchanged.
- SPDR write with wffull=0:
  - wfwe pulses;
  - XCNT increments, wrapping FF→00.
- Simultaneous XCNT-clear write and push cannot occur (single port). Clear always wins over increment.

Read path:
- data_out is registered every cycle from the decoded port_id, regardless of read_strobe. It holds 0 for unmapped port_id.
- SPDR read with read_strobe=1 and rfempty=0: rfre pulses for exactly one cycle, the cycle after the strobe, so the data already captured is consumed.
- SPDR read with rfempty=1: no rfre, and data_out=rfdout (undefined data).
- read_strobe held for N consecutive cycles on SPDR produces exactly one rfre. Detection is on the rising edge of the strobe-and-hit condition.

Reset mid-operation:
- Pending pulses are cancelled the cycle reset is sampled.
- ss_n returns to SS_RESET.

Optional Feature:
- Macro: SPI_REGS_MC_IRQ_EN.
- With the macro:
  - IER at offset 7, RW, reset 0. bit0 enables SPIF, bit1 enables OVF, bit2 enables "read FIFO not empty".
  - irq is registered: irq = OR of (enabled sources), updated each cycle, 1 cycle latency.
- Without the macro:
  - IER logic is absent;
  - offset 7 reads 0;
  - irq is tied 0.

Decomposition:
- Shared package spi_pkg holds:
  - register offset constants (SPCR_OFS..IER_OFS);
  - SPSR bit indices SPIF_BIT=7, WCOL_BIT=6;
  - XSR bit indices.
- One natural sub-module, spi_strobe_pulse: edge-detects strobe&&hit and produces a registered one-cycle pulse. It is instanced for wfwe, rfre and the clear pulses.

Test Plan:
- Reset, then read all 8 offsets at BASE_ADDRESS=8'h40 → SPCR/SPER/XCNT read 00, SSR reads 0F (NUM_SS=4), no pulses.
- Write 8'hA5 to port 8'h43 with wffull=0, three times → three single-cycle wfwe with wfdin=A5; XCNT reads 03.
- Set wffull=1, write SPDR → no wfwe; XSR bit0=1. Write 01 to XSR → reads 04 (wffull still 1).
- rfempty=0, rfdout=3C, hold read_strobe 3 cycles on SPDR → data_out=3C, exactly one rfre one cycle after the strobe edge.
- Write C0 to SPSR → clear_spif and clear_wcol each pulse once, same cycle. Write 80 → only clear_spif pulses.
- With SPI_REGS_MC_IRQ_EN: IER=01, spsr[7]=1 → irq=1 next cycle; IER=00 → irq=0. Without the macro, irq stays 0.
